ps2_rx: RTL and testbench

//  PS/2 device-to-host serial receiver. Samples the raw keyboard ps2_clk/ps2_data pins
//  and assembles 11-bit frames (start, 8 data LSB-first, odd parity, stop).

---
 rtl/vga_pkg.sv | 6 +
 rtl/ps2_clk_filter.sv | 47 ++++
 rtl/ps2_rx.sv | 97 +++++++++
 tb/tb_ps2_rx.sv | 147 ++++++++++++++
 4 files changed

// File: rtl/vga_pkg.sv
// vga_pkg: constants and PS/2 receiver state encoding shared by ps2_rx, keyboard_decode and benches
package vga_pkg;
   localparam int PS2_FRAME_DATA_BITS = 8;
   localparam logic [7:0] PS2_BREAK_CODE = 8'hF0;
   typedef enum logic [1:0] {IDLE, DATA, PARITY, STOP} ps2_state_t;
endpackage

// File: rtl/ps2_clk_filter.sv
// ps2_clk_filter: synchronises the PS/2 pins, debounces ps2_clk and flags its falling edges
//   clk, rst        system clock, synchronous active-high reset
//   ps2_clk         raw PS/2 clock pin (asynchronous, idle high)
//   ps2_data        raw PS/2 data pin (asynchronous, idle high)
//   fall_tick       one-cycle pulse on each filtered 1->0 transition of ps2_clk
//   data_sync       synchronised ps2_data
module ps2_clk_filter #(
   parameter int FILTER_LEN = 8
) (
   input  logic clk,
   input  logic rst,
   input  logic ps2_clk,
   input  logic ps2_data,
   output logic fall_tick,
   output logic data_sync
);
   logic [1:0]            r_clk_sync;
   logic [1:0]            r_data_sync;
   logic [FILTER_LEN-1:0] r_hist;
   logic                  r_filt;
   logic                  r_fall;
   logic [FILTER_LEN-1:0] w_hist;
   logic                  w_filt;
   // the filtered level only moves when the whole sample window agrees
   always_comb begin
      w_hist = {r_hist[FILTER_LEN-2:0], r_clk_sync[1]};
      w_filt = (&w_hist) ? 1'b1 : (~|w_hist) ? 1'b0 : r_filt;
   end
   // everything presets to the idle-high line so no edge follows reset
   always_ff @(posedge clk) begin
      if (rst) begin
         r_clk_sync  <= '1;
         r_data_sync <= '1;
         r_hist      <= '1;
         r_filt      <= 1'b1;
         r_fall      <= 1'b0;
      end else begin
         r_clk_sync  <= {r_clk_sync[0], ps2_clk};
         r_data_sync <= {r_data_sync[0], ps2_data};
         r_hist      <= w_hist;
         r_filt      <= w_filt;
         r_fall      <= r_filt & ~w_filt;
      end
   end
   assign fall_tick = r_fall;
   assign data_sync = r_data_sync[1];
endmodule

// File: rtl/ps2_rx.sv
// ps2_rx: PS/2 device-to-host receiver assembling 11-bit frames into bytes
//   clk, rst        system clock, synchronous active-high reset
//   ps2_clk         raw PS/2 clock pin
//   ps2_data        raw PS/2 data pin
//   rx_en           accept new frames (checked only when idle)
//   rx_done_tick    one-cycle pulse, dout holds a new valid byte
//   dout            last valid byte, held until the next valid frame
//   rx_err          one-cycle pulse on parity, stop or timeout error
module ps2_rx
   import vga_pkg::*;
#(
   parameter int FILTER_LEN  = 8,
   parameter int TIMEOUT_CYC = 130000
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       ps2_clk,
   input  logic       ps2_data,
   input  logic       rx_en,
   output logic       rx_done_tick,
   output logic [7:0] dout,
   output logic       rx_err
);
   localparam int TW = $clog2(TIMEOUT_CYC + 1);
   ps2_state_t r_state, w_state_nxt;
   logic [2:0]    r_bit_cnt;
   logic [7:0]    r_shift;
   logic          r_parity;
   logic [TW-1:0] r_tcnt;
   logic [7:0]    r_dout;
   logic          r_done;
   logic          r_err;
   logic          w_fall;
   logic          w_data;
   logic          w_timeout;
   logic          w_edge;
   logic          w_done;
   logic          w_err;
   ps2_clk_filter #(.FILTER_LEN(FILTER_LEN)) u_filter (
      .clk       (clk),
      .rst       (rst),
      .ps2_clk   (ps2_clk),
      .ps2_data  (ps2_data),
      .fall_tick (w_fall),
      .data_sync (w_data)
   );
   // a timeout in the same cycle as an edge wins and the edge is dropped
   always_comb begin
      w_state_nxt = r_state;
      w_done      = 1'b0;
      w_err       = 1'b0;
      w_timeout   = (r_state != IDLE) && (r_tcnt == TW'(TIMEOUT_CYC - 1));
      w_edge      = w_fall && !w_timeout;
      if (w_timeout) begin
         w_state_nxt = IDLE;
         w_err       = 1'b1;
      end else if (w_fall) begin
         case (r_state)
            IDLE:    w_state_nxt = (rx_en && !w_data) ? DATA : IDLE;
            DATA:    w_state_nxt = (r_bit_cnt == 3'd7) ? PARITY : DATA;
            PARITY:  w_state_nxt = STOP;
            default: begin
               w_state_nxt = IDLE;
               w_done      = w_data && (^{r_shift, r_parity});
               w_err       = !w_done;
            end
         endcase
      end
   end
   always_ff @(posedge clk) begin
      if (rst) begin
         r_state   <= IDLE;
         r_bit_cnt <= '0;
         r_shift   <= '0;
         r_parity  <= 1'b0;
         r_tcnt    <= '0;
         r_dout    <= '0;
         r_done    <= 1'b0;
         r_err     <= 1'b0;
      end else begin
         r_state <= w_state_nxt;
         r_done  <= w_done;
         r_err   <= w_err;
         r_tcnt  <= (r_state == IDLE || w_fall) ? '0 : r_tcnt + 1'b1;
         if (w_done) r_dout <= r_shift;
         if (w_edge && r_state == IDLE) r_bit_cnt <= '0;
         if (w_edge && r_state == DATA) begin
            r_shift   <= {w_data, r_shift[7:1]};
            r_bit_cnt <= r_bit_cnt + 3'd1;
         end
         if (w_edge && r_state == PARITY) r_parity <= w_data;
      end
   end
   assign rx_done_tick = r_done;
   assign rx_err       = r_err;
   assign dout         = r_dout;
endmodule

// File: tb/tb_ps2_rx.sv
// tb_ps2_rx: scoreboard bench driving PS/2 frames into ps2_rx
module tb_ps2_rx;
   localparam int TIMEOUT = 600;
   localparam int H = 20;
   logic       clk = 1'b0;
   logic       rst = 1'b1;
   logic       ps2_clk = 1'b1;
   logic       ps2_data = 1'b1;
   logic       rx_en = 1'b1;
   logic       rx_done_tick;
   logic [7:0] dout;
   logic       rx_err;
   int n_tests = 0;
   int n_fail = 0;
   typedef struct {
      bit         is_err;
      logic [7:0] val;
   } exp_t;
   exp_t sb[$];
   ps2_rx #(.FILTER_LEN(8), .TIMEOUT_CYC(TIMEOUT)) dut (
      .clk          (clk),
      .rst          (rst),
      .ps2_clk      (ps2_clk),
      .ps2_data     (ps2_data),
      .rx_en        (rx_en),
      .rx_done_tick (rx_done_tick),
      .dout         (dout),
      .rx_err       (rx_err)
   );
   always #5 clk = ~clk;
   task automatic cyc(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask
   task automatic check(input string name, input logic [7:0] act, input logic [7:0] req);
      n_tests++;
      if (act !== req) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h", name, act, req);
      end
   endtask
   task automatic push(input bit is_err, input logic [7:0] v);
      exp_t e;
      e.is_err = is_err;
      e.val    = v;
      sb.push_back(e);
   endtask
   // nbits truncates the frame; glitch_bit adds a short low pulse; rst_bit resets mid-bit and abandons the frame
   task automatic send(input logic [7:0] b, input logic par, input int nbits, input int glitch_bit, input int rst_bit);
      logic [10:0] f;
      f = {1'b1, par, b, 1'b0};
      for (int i = 0; i < nbits; i++) begin
         cyc(H / 2);
         ps2_data = f[i];
         if (i == glitch_bit) begin
            ps2_clk = 1'b0;
            cyc(3);
            ps2_clk = 1'b1;
         end
         if (i == rst_bit) begin
            rst = 1'b1;
            cyc(2);
            rst = 1'b0;
            ps2_data = 1'b1;
            cyc(H);
            return;
         end
         cyc(H / 2);
         ps2_clk = 1'b0;
         cyc(H);
         ps2_clk = 1'b1;
      end
      ps2_data = 1'b1;
   endtask
   task automatic drained(input string name);
      cyc(30);
      check(name, 8'(sb.size()), 8'd0);
      sb.delete();
   endtask
   always @(negedge clk) begin
      if (!rst && (rx_done_tick || rx_err)) begin
         exp_t e;
         n_tests++;
         if (rx_done_tick && rx_err) begin
            n_fail++;
            $display("FAIL both_pulses: tick=1 err=1 expected only one");
         end else if (sb.size() == 0) begin
            n_fail++;
            $display("FAIL unexpected_event: tick=%b err=%b dout=%h expected no event", rx_done_tick, rx_err, dout);
         end else begin
            e = sb.pop_front();
            if (e.is_err !== rx_err || e.val !== dout) begin
               n_fail++;
               $display("FAIL event: err=%b dout=%h expected err=%b dout=%h", rx_err, dout, e.is_err, e.val);
            end
         end
      end
   end
   initial begin
      cyc(5);
      check("reset_dout", dout, 8'h00);
      check("reset_tick", {7'd0, rx_done_tick}, 8'd0);
      check("reset_err", {7'd0, rx_err}, 8'd0);
      rst = 1'b0;
      cyc(40);
      check("no_spurious_after_reset", 8'(sb.size()), 8'd0);
      push(0, 8'h1C);
      send(8'h1C, 1'b0, 11, -1, -1);
      drained("t1_1C");
      push(0, 8'hF0);
      push(0, 8'h1C);
      send(8'hF0, 1'b1, 11, -1, -1);
      send(8'h1C, 1'b0, 11, -1, -1);
      drained("t2_back_to_back");
      push(1, 8'h1C);
      send(8'h23, 1'b1, 11, -1, -1);
      drained("t3_parity_err");
      check("t3_dout_held", dout, 8'h1C);
      push(0, 8'h1B);
      send(8'h1B, 1'b1, 11, 4, -1);
      drained("t4_glitch");
      push(1, 8'h1B);
      send(8'h55, 1'b1, 5, -1, -1);
      cyc(TIMEOUT + 100);
      drained("t5_timeout");
      check("t5_dout_held", dout, 8'h1B);
      push(0, 8'h76);
      send(8'h76, 1'b0, 11, -1, -1);
      drained("t5_after_timeout");
      send(8'h16, 1'b0, 11, -1, 5);
      check("t6_dout_after_rst", dout, 8'h00);
      drained("t6_no_tick_after_rst");
      push(0, 8'h16);
      send(8'h16, 1'b0, 11, -1, -1);
      drained("t6_after_rst");
      rx_en = 1'b0;
      send(8'h55, 1'b1, 11, -1, -1);
      drained("t7_rx_en_off");
      check("t7_dout_held", dout, 8'h16);
      rx_en = 1'b1;
      push(0, 8'h5A);
      send(8'h5A, ~^8'h5A, 11, -1, -1);
      drained("t8_5A");
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end
endmodule
